mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of req_addr and mem_addr.
REQ-002 Parameter MISALIGN_SPLIT, default 1: 1 = misaligned half/word accesses split into two word accesses; 0 = misaligned access raises exception, no memory access.
REQ-003 Data width fixed at 32 bits (uint32); byte lane k = bits 8k+7:8k, little-endian (address offset 0 -> bits 7:0).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  core access request valid.
REQ-007 req_ready  out  1  unit can accept a request (high only in IDLE).
REQ-008 req_type  in  mem_inst_type_t  MEM_LB/LH/LW/LBU/LHU/SB/SH/SW; any other encoding = no-op.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 mem_req  out  1  memory request valid.
REQ-012 mem_gnt  in  1  memory accepts request this cycle.
REQ-013 mem_we  out  1  1 = write.
REQ-014 mem_addr  out  ADDR_W  word-aligned address (bits 1:0 = 0).
REQ-015 mem_be  out  4  byte enables.
REQ-016 mem_wdata  out  32  lane-shifted write data.
REQ-017 mem_rvalid  in  1  read data / write ack, exactly one per granted request.
REQ-018 mem_rdata  in  32  read word.
REQ-019 rsp_valid  out  1  response valid.
REQ-020 rsp_ready  in  1  core accepts response.
REQ-021 rsp_data  out  32  extended load result; 0 for stores, no-ops, exceptions.
REQ-022 rsp_exc  out  1  misaligned-access exception.

Function
REQ-023 States SHALL be IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP; one access outstanding at a time.
REQ-024 IDLE: req_valid && req_ready latches type, addr, wdata; next state REQ0, or RESP directly for no-op or exception case.
REQ-025 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0; split needed only if misaligned AND bytes cross a word boundary (half at offset 3, any misaligned word).
REQ-026 Half at offset 1 is misaligned but in-word: with MISALIGN_SPLIT=1 single access, lanes 2:1; with MISALIGN_SPLIT=0 exception.
REQ-027 MISALIGN_SPLIT=0 and misaligned: go to RESP, rsp_exc=1, rsp_data=0, mem_req never asserted.
REQ-028 REQ0/REQ1: mem_req=1, outputs held stable until mem_gnt; on gnt go to WAIT0/WAIT1.
REQ-029 First access: mem_addr = {addr[ADDR_W-1:2],2'b00}; second: that +4, wraps modulo 2^ADDR_W.
REQ-030 Byte enables: byte 0001<<off; half 0011<<off truncated to 4 bits; word 1111<<off truncated; second access gets remaining lanes from bit 0 (e.g., word off 1: 1110 then 0001).
REQ-031 mem_wdata = wdata<<(8*off) first access, wdata>>(8*(4-off)) second.
REQ-032 WAIT0: on mem_rvalid capture low part (rdata>>(8*off)); go to REQ1 if split, else RESP. WAIT1: capture, merge high part at bit 8*(4-off), go to RESP.
REQ-033 Load extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW unchanged.
REQ-034 RESP: rsp_valid=1, rsp_data/rsp_exc stable until rsp_ready; on rsp_ready go IDLE.
REQ-035 Minimum latency aligned access with gnt and rvalid immediate: accept cycle T, mem_req T+1, rvalid T+2, rsp_valid T+3; split adds 2 cycles.
REQ-036 mem_rvalid outside WAIT0/WAIT1 SHALL be ignored; mem_gnt outside REQ0/REQ1 ignored.

Reset
REQ-037 rst_n low SHALL asynchronously force IDLE, req_ready=1 once released, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_exc=0.
REQ-038 Reset mid-access SHALL abandon the transaction; no response issued after reset release.

Verification
REQ-039 LB addr 0x103, mem_rdata 0x80FFFFFF -> mem_addr 0x100, be 1000, rsp_data 0xFFFFFF80, exc 0, rsp_valid at T+3.
REQ-040 SW addr 0x1FE, wdata 0xAABBCCDD, SPLIT=1 -> access 1: addr 0x1FC be 1100 wdata 0xCCDD0000; access 2: addr 0x200 be 0011 wdata 0x0000AABB; rsp exc 0.
REQ-041 LHU addr 0x203, SPLIT=1, rdata 0x12xxxxxx then 0xxxxxxx34 -> rsp_data 0x00003412.
REQ-042 LW addr 0x101, SPLIT=0 -> rsp_valid with exc 1, data 0, mem_req never high.
REQ-043 mem_gnt held low 5 cycles, rsp_ready held low 3 cycles -> mem outputs and rsp outputs stable throughout, req_ready 0.
REQ-044 rst_n low during WAIT1 -> all outputs at reset values immediately; late mem_rvalid after release produces no rsp_valid.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: core request, memory bus and response signals of the memory access unit.
interface mem_access_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_exc;
  modport master (
    input  req_valid, req_type, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata, rsp_ready,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_data, rsp_exc
  );
  modport slave (
    output req_valid, req_type, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata, rsp_ready,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_data, rsp_exc
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit, splitting word-crossing accesses into two bus cycles.
// req_type: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW, anything else is a no-op.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  mem_access_if.master bus
);
  localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd3, LHU = 4'd4, SB = 4'd5, SH = 4'd6, SW = 4'd7;
  localparam logic [2:0] IDLE = 3'd0, REQ0 = 3'd1, WAIT0 = 3'd2, REQ1 = 3'd3, WAIT1 = 3'd4, RESP = 3'd5;
  logic [2:0]        r_state;
  logic [3:0]        r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_rd, r_rsp_data;
  logic              r_exc;
  logic [1:0]        w_in_size, w_size, w_off;
  logic              w_in_mis, w_in_exc, w_split, w_store, w_req0, w_req1, w_mem_req;
  logic [4:0]        w_sh_lo;
  logic [5:0]        w_sh_hi;
  logic [3:0]        w_be_base;
  logic [7:0]        w_be_full;
  logic [63:0]       w_wd_full;
  logic [ADDR_W-1:0] w_base;
  // size code: 0 byte, 1 half, 2 word, 3 no-op
  function automatic logic [1:0] f_size(input logic [3:0] t);
    return (t == LB || t == LBU || t == SB) ? 2'd0 :
           (t == LH || t == LHU || t == SH) ? 2'd1 :
           (t == LW || t == SW) ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [31:0] f_ext(input logic [3:0] t, input logic [31:0] d);
    return t == LB  ? {{24{d[7]}}, d[7:0]} :
           t == LH  ? {{16{d[15]}}, d[15:0]} :
           t == LW  ? d :
           t == LBU ? {24'd0, d[7:0]} :
           t == LHU ? {16'd0, d[15:0]} : 32'd0;
  endfunction
  assign w_in_size = f_size(bus.req_type);
  assign w_in_mis  = (w_in_size == 2'd1 && bus.req_addr[0]) || (w_in_size == 2'd2 && bus.req_addr[1:0] != 2'd0);
  assign w_in_exc  = !MISALIGN_SPLIT && w_in_mis;
  assign w_size    = f_size(r_type);
  assign w_off     = r_addr[1:0];
  assign w_split   = MISALIGN_SPLIT && ((w_size == 2'd1 && w_off == 2'd3) || (w_size == 2'd2 && w_off != 2'd0));
  assign w_store   = r_type == SB || r_type == SH || r_type == SW;
  assign w_sh_lo   = {w_off, 3'b000};
  assign w_sh_hi   = 6'd32 - {1'b0, w_off, 3'b000};
  assign w_be_base = w_size == 2'd0 ? 4'b0001 : w_size == 2'd1 ? 4'b0011 : 4'b1111;
  // Upper halves of these wide shifts are exactly the lanes of the second access.
  assign w_be_full = {4'b0000, w_be_base} << w_off;
  assign w_wd_full = {32'd0, r_wdata} << w_sh_lo;
  assign w_base    = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_req0    = r_state == REQ0;
  assign w_req1    = r_state == REQ1;
  assign w_mem_req = w_req0 || w_req1;
  assign bus.req_ready = r_state == IDLE;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_req && w_store;
  assign bus.mem_addr  = w_req1 ? w_base + ADDR_W'(4) : w_req0 ? w_base : '0;
  assign bus.mem_be    = w_req1 ? w_be_full[7:4] : w_req0 ? w_be_full[3:0] : 4'd0;
  assign bus.mem_wdata = w_req1 ? w_wd_full[63:32] : w_req0 ? w_wd_full[31:0] : 32'd0;
  assign bus.rsp_valid = r_state == RESP;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_exc   = r_exc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_type     <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_rd       <= 32'd0;
      r_rsp_data <= 32'd0;
      r_exc      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_type     <= bus.req_type;
          r_addr     <= bus.req_addr;
          r_wdata    <= bus.req_wdata;
          r_rsp_data <= 32'd0;
          r_exc      <= w_in_exc;
          r_state    <= (w_in_size == 2'd3 || w_in_exc) ? RESP : REQ0;
        end
        REQ0: if (bus.mem_gnt) r_state <= WAIT0;
        WAIT0: if (bus.mem_rvalid) begin
          r_rd       <= bus.mem_rdata >> w_sh_lo;
          r_rsp_data <= w_split ? 32'd0 : f_ext(r_type, bus.mem_rdata >> w_sh_lo);
          r_state    <= w_split ? REQ1 : RESP;
        end
        REQ1: if (bus.mem_gnt) r_state <= WAIT1;
        WAIT1: if (bus.mem_rvalid) begin
          r_rsp_data <= f_ext(r_type, r_rd | (bus.mem_rdata << w_sh_hi));
          r_state    <= RESP;
        end
        RESP: if (bus.rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule
